// File: rtl/frog_game_ctrl.sv
// rtl/frog_game_ctrl.sv - frame-ticked frog/croc game state controller
// Hit overlap accumulates per pixel; everything else moves once per v-sync rising edge.
module frog_game_ctrl #(
  parameter int STEP          = 2,
  parameter int CROC1_SPD     = 1,
  parameter int CROC2_SPD     = 2,
  parameter int CROC3_SPD     = 3,
  parameter int FREEZE_FRAMES = 60,
  parameter int START_X       = 152,
  parameter int START_Y       = 240,
  parameter int FROG_XMIN     = 152,
  parameter int FROG_XMAX     = 743,
  parameter int FROG_YMIN     = 40,
  parameter int FROG_YMAX     = 471,
  parameter int CROC_MIN      = 32,
  parameter int CROC_MAX      = 400
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       vga_v_sync,
  input  logic       InFrog,
  input  logic       InCroc,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [9:0] FrogX,
  output logic [9:0] FrogY,
  output logic [8:0] CrocY1,
  output logic [8:0] CrocY2,
  output logic [8:0] CrocY3,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {S_PLAY, S_HIT, S_WIN, S_OVER} state_t;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMIN_S = 11'(FROG_XMIN);
  localparam logic signed [10:0] XMAX_S = 11'(FROG_XMAX);
  localparam logic signed [10:0] YMIN_S = 11'(FROG_YMIN);
  localparam logic signed [10:0] YMAX_S = 11'(FROG_YMAX);
  localparam logic [9:0] XMAX_U   = 10'(FROG_XMAX);
  localparam logic [9:0] START_XU = 10'(START_X);
  localparam logic [9:0] START_YU = 10'(START_Y);
  localparam logic [9:0] CMIN     = 10'(CROC_MIN);
  localparam logic [9:0] CMAX     = 10'(CROC_MAX);
  localparam logic [9:0] SPD1     = 10'(CROC1_SPD);
  localparam logic [9:0] SPD2     = 10'(CROC2_SPD);
  localparam logic [9:0] SPD3     = 10'(CROC3_SPD);
  localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_FRAMES - 1);

  state_t            state_q, state_d;
  logic              vs_q;
  logic              hit_q, hit_d;
  logic [7:0]        freeze_q, freeze_d;
  logic [9:0]        frog_x_q, frog_x_d, frog_y_q, frog_y_d;
  logic [8:0]        c1_y_q, c1_y_d, c2_y_q, c2_y_d, c3_y_q, c3_y_d;
  logic              c1_dn_q, c1_dn_d, c2_dn_q, c2_dn_d, c3_dn_q, c3_dn_d;
  logic [3:0]        score_q, score_d;
  logic [1:0]        lives_q, lives_d;
  logic              go_q;
  logic              tick, overlap;
  logic signed [10:0] nx, ny;
  logic [9:0]        c1_n, c2_n, c3_n;

  // Returns {direction, position}; direction 1 means moving down.
  function automatic logic [9:0] croc_step(input logic [8:0] y, input logic dn,
                                           input logic [9:0] spd);
    logic [9:0] y10, sum, diff;
    y10  = {1'b0, y};
    sum  = y10 + spd;
    diff = y10 - spd;
    if (dn) begin
      if (sum > CMAX) croc_step = {1'b0, CMAX[8:0]};
      else            croc_step = {1'b1, sum[8:0]};
    end else begin
      if (y10 < CMIN + spd) croc_step = {1'b1, CMIN[8:0]};
      else                  croc_step = {1'b0, diff[8:0]};
    end
  endfunction

  assign tick    = vga_v_sync & ~vs_q;
  assign overlap = InFrog & InCroc;
  assign c1_n    = croc_step(c1_y_q, c1_dn_q, SPD1);
  assign c2_n    = croc_step(c2_y_q, c2_dn_q, SPD2);
  assign c3_n    = croc_step(c3_y_q, c3_dn_q, SPD3);

  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q  <= S_PLAY;
      vs_q     <= 1'b0;
      hit_q    <= 1'b0;
      freeze_q <= 8'd0;
      frog_x_q <= START_XU;
      frog_y_q <= START_YU;
      c1_y_q   <= 9'd32;
      c1_dn_q  <= 1'b1;
      c2_y_q   <= 9'd200;
      c2_dn_q  <= 1'b1;
      c3_y_q   <= 9'd400;
      c3_dn_q  <= 1'b0;
      score_q  <= 4'd0;
      lives_q  <= 2'd3;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vga_v_sync;
      hit_q    <= hit_d;
      freeze_q <= freeze_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      c1_y_q   <= c1_y_d;
      c1_dn_q  <= c1_dn_d;
      c2_y_q   <= c2_y_d;
      c2_dn_q  <= c2_dn_d;
      c3_y_q   <= c3_y_d;
      c3_dn_q  <= c3_dn_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      go_q     <= (state_d == S_OVER);
    end
  end

  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    freeze_d = freeze_q;
    frog_x_d = frog_x_q;
    frog_y_d = frog_y_q;
    score_d  = score_q;
    lives_d  = lives_q;
    {c1_dn_d, c1_y_d} = {c1_dn_q, c1_y_q};
    {c2_dn_d, c2_y_d} = {c2_dn_q, c2_y_q};
    {c3_dn_d, c3_y_d} = {c3_dn_q, c3_y_q};

    // Opposing buttons cancel; signed 11-bit math keeps the clamp from wrapping.
    nx = $signed({1'b0, frog_x_q});
    ny = $signed({1'b0, frog_y_q});
    if (btn_right & ~btn_left)      nx = nx + STEP_S;
    else if (btn_left & ~btn_right) nx = nx - STEP_S;
    if (btn_down & ~btn_up)         ny = ny + STEP_S;
    else if (btn_up & ~btn_down)    ny = ny - STEP_S;
    if (nx < XMIN_S)      nx = XMIN_S;
    else if (nx > XMAX_S) nx = XMAX_S;
    if (ny < YMIN_S)      ny = YMIN_S;
    else if (ny > YMAX_S) ny = YMAX_S;

    if (tick && state_q != S_OVER) begin
      {c1_dn_d, c1_y_d} = c1_n;
      {c2_dn_d, c2_y_d} = c2_n;
      {c3_dn_d, c3_y_d} = c3_n;
    end

    case (state_q)
      S_PLAY: begin
        if (tick) begin
          hit_d = overlap;
          if (hit_q) begin
            lives_d  = lives_q - 2'd1;
            freeze_d = 8'd0;
            state_d  = S_HIT;
          end else if (frog_x_q >= XMAX_U) begin
            score_d  = score_q + 4'd1;
            freeze_d = 8'd0;
            state_d  = S_WIN;
          end else begin
            frog_x_d = nx[9:0];
            frog_y_d = ny[9:0];
          end
        end else if (overlap) begin
          hit_d = 1'b1;
        end
      end
      S_HIT, S_WIN: begin
        if (tick) begin
          freeze_d = freeze_q + 8'd1;
          if (freeze_q == FREEZE_LAST) begin
            frog_x_d = START_XU;
            frog_y_d = START_YU;
            hit_d    = 1'b0;
            state_d  = (lives_q == 2'd0) ? S_OVER : S_PLAY;
          end
        end
      end
      S_OVER: begin
        if (tick && btn_start) begin
          lives_d  = 2'd3;
          score_d  = 4'd0;
          frog_x_d = START_XU;
          frog_y_d = START_YU;
          hit_d    = 1'b0;
          state_d  = S_PLAY;
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  assign FrogX     = frog_x_q;
  assign FrogY     = frog_y_q;
  assign CrocY1    = c1_y_q;
  assign CrocY2    = c2_y_q;
  assign CrocY3    = c3_y_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb/tb_frog_game_ctrl.sv - directed bench for frog_game_ctrl
module tb_frog_game_ctrl;

  logic       dclk, rst, vga_v_sync, InFrog, InCroc;
  logic       btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [9:0] FrogX, FrogY;
  logic [8:0] CrocY1, CrocY2, CrocY3;
  logic [3:0] score;
  logic [1:0] lives;
  logic       game_over;
  int         errors, checks, croc_ticks;

  frog_game_ctrl dut (
    .dclk(dclk), .rst(rst), .vga_v_sync(vga_v_sync), .InFrog(InFrog), .InCroc(InCroc),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_start(btn_start), .FrogX(FrogX), .FrogY(FrogY), .CrocY1(CrocY1), .CrocY2(CrocY2),
    .CrocY3(CrocY3), .score(score), .lives(lives), .game_over(game_over)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  function automatic int croc_after(input int y0, input bit d0, input int spd, input int n);
    int y;
    bit d;
    y = y0;
    d = d0;
    for (int i = 0; i < n; i++) begin
      if (d) begin
        if (y + spd > 400) begin y = 400; d = 1'b0; end
        else y = y + spd;
      end else begin
        if (y - spd < 32) begin y = 32; d = 1'b1; end
        else y = y - spd;
      end
    end
    return y;
  endfunction

  task automatic clear_inputs();
    vga_v_sync = 0; InFrog = 0; InCroc = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_start = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (3) @(negedge dclk);
    rst = 0;
    croc_ticks = 0;
  endtask

  // One frame: sync high two cycles, low four; optional overlap on the tick cycle.
  task automatic do_frame(input bit ov_on_tick);
    @(negedge dclk);
    vga_v_sync = 1; InFrog = ov_on_tick; InCroc = ov_on_tick;
    @(negedge dclk);
    InFrog = 0; InCroc = 0;
    @(negedge dclk);
    vga_v_sync = 0;
    repeat (3) @(negedge dclk);
    croc_ticks++;
  endtask

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) do_frame(1'b0);
  endtask

  task automatic pulse_overlap();
    @(negedge dclk);
    InFrog = 1; InCroc = 1;
    @(negedge dclk);
    InFrog = 0; InCroc = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; vga_v_sync = 1;
    repeat (3) @(negedge dclk);
    vga_v_sync = 0;
    @(negedge dclk);
    rst = 0;
    croc_ticks = 0;
    checks++;
    if ({FrogX, FrogY} !== {10'd152, 10'd240}) begin
      errors++; $display("FAIL reset_frog got %0d,%0d want 152,240", FrogX, FrogY);
    end
    checks++;
    if ({CrocY1, CrocY2, CrocY3} !== {9'd32, 9'd200, 9'd400}) begin
      errors++; $display("FAIL reset_crocs got %0d,%0d,%0d want 32,200,400", CrocY1, CrocY2, CrocY3);
    end
    checks++;
    if ({score, lives, game_over} !== {4'd0, 2'd3, 1'b0}) begin
      errors++; $display("FAIL reset_status got s=%0d l=%0d go=%0d want 0,3,0", score, lives, game_over);
    end
    do_frame(1'b0);
    checks++;
    if ({FrogX, FrogY} !== {10'd152, 10'd240}) begin
      errors++; $display("FAIL frame1_frog got %0d,%0d want 152,240", FrogX, FrogY);
    end
    checks++;
    if ({CrocY1, CrocY2, CrocY3} !== {9'd33, 9'd202, 9'd397}) begin
      errors++; $display("FAIL frame1_crocs got %0d,%0d,%0d want 33,202,397", CrocY1, CrocY2, CrocY3);
    end
  endtask

  task automatic test_long_vsync();
    do_reset();
    @(negedge dclk);
    vga_v_sync = 1;
    repeat (20) @(negedge dclk);
    vga_v_sync = 0;
    repeat (3) @(negedge dclk);
    checks++;
    if ({CrocY1, CrocY3} !== {9'd33, 9'd397}) begin
      errors++; $display("FAIL long_vsync got c1=%0d c3=%0d want 33,397", CrocY1, CrocY3);
    end
  endtask

  task automatic test_move_clamp();
    do_reset();
    btn_right = 1;
    do_frames(296);
    checks++;
    if ({FrogX, score} !== {10'd743, 4'd0}) begin
      errors++; $display("FAIL right_clamp got x=%0d s=%0d want 743,0", FrogX, score);
    end
    do_frame(1'b0);
    checks++;
    if ({FrogX, score} !== {10'd743, 4'd1}) begin
      errors++; $display("FAIL win_score got x=%0d s=%0d want 743,1", FrogX, score);
    end
    btn_down = 1;
    do_frames(59);
    checks++;
    if ({FrogX, FrogY} !== {10'd743, 10'd240}) begin
      errors++; $display("FAIL win_freeze got %0d,%0d want 743,240", FrogX, FrogY);
    end
    btn_down = 0; btn_right = 0;
    do_frame(1'b0);
    checks++;
    if ({FrogX, FrogY} !== {10'd152, 10'd240}) begin
      errors++; $display("FAIL win_respawn got %0d,%0d want 152,240", FrogX, FrogY);
    end
    do_frame(1'b0);
    checks++;
    if ({FrogX, FrogY, score} !== {10'd152, 10'd240, 4'd1}) begin
      errors++; $display("FAIL after_win got %0d,%0d s=%0d want 152,240,1", FrogX, FrogY, score);
    end
  endtask

  task automatic test_cancel();
    btn_right = 1;
    do_frames(5);
    checks++;
    if (FrogX !== 10'd162) begin
      errors++; $display("FAIL step_right got %0d want 162", FrogX);
    end
    btn_left = 1;
    do_frames(10);
    checks++;
    if (FrogX !== 10'd162) begin
      errors++; $display("FAIL cancel_lr got %0d want 162", FrogX);
    end
    btn_right = 0;
    do_frames(10);
    checks++;
    if (FrogX !== 10'd152) begin
      errors++; $display("FAIL left_clamp got %0d want 152", FrogX);
    end
    btn_left = 0; btn_up = 1;
    do_frames(200);
    checks++;
    if ({FrogX, FrogY} !== {10'd152, 10'd40}) begin
      errors++; $display("FAIL up_clamp got %0d,%0d want 152,40", FrogX, FrogY);
    end
    btn_up = 0;
  endtask

  task automatic test_game_over();
    int n, e1, e2, e3;
    for (int k = 1; k <= 3; k++) begin
      pulse_overlap();
      do_frame(1'b0);
      checks++;
      if (lives !== 2'(3 - k)) begin
        errors++; $display("FAIL hit%0d_lives got %0d want %0d", k, lives, 3 - k);
      end
      if (k < 3) do_frames(60);
    end
    do_frames(59);
    checks++;
    if ({lives, game_over} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL pre_over got l=%0d go=%0d want 0,0", lives, game_over);
    end
    do_frame(1'b0);
    checks++;
    if ({game_over, FrogX, FrogY} !== {1'b1, 10'd152, 10'd240}) begin
      errors++; $display("FAIL enter_over got go=%0d %0d,%0d want 1,152,240", game_over, FrogX, FrogY);
    end
    n = croc_ticks;
    e1 = croc_after(32, 1'b1, 1, n);
    e2 = croc_after(200, 1'b1, 2, n);
    e3 = croc_after(400, 1'b0, 3, n);
    btn_right = 1;
    do_frames(5);
    checks++;
    if ({CrocY1, CrocY2, CrocY3, FrogX} !== {9'(e1), 9'(e2), 9'(e3), 10'd152}) begin
      errors++; $display("FAIL over_hold got %0d,%0d,%0d x=%0d want %0d,%0d,%0d x=152",
                         CrocY1, CrocY2, CrocY3, FrogX, e1, e2, e3);
    end
    btn_right = 0; btn_start = 1;
    do_frame(1'b0);
    btn_start = 0;
    checks++;
    if ({lives, score, game_over} !== {2'd3, 4'd0, 1'b0}) begin
      errors++; $display("FAIL restart got l=%0d s=%0d go=%0d want 3,0,0", lives, score, game_over);
    end
    do_frame(1'b0);
    e1 = croc_after(32, 1'b1, 1, n + 1);
    checks++;
    if (CrocY1 !== 9'(e1)) begin
      errors++; $display("FAIL restart_croc got %0d want %0d", CrocY1, e1);
    end
  endtask

  task automatic test_hit();
    do_reset();
    btn_down = 1;
    do_frames(5);
    pulse_overlap();
    do_frame(1'b0);
    checks++;
    if ({lives, FrogY} !== {2'd2, 10'd250}) begin
      errors++; $display("FAIL hit_enter got l=%0d y=%0d want 2,250", lives, FrogY);
    end
    do_frames(10);
    pulse_overlap();
    do_frames(49);
    checks++;
    if ({lives, FrogY} !== {2'd2, 10'd250}) begin
      errors++; $display("FAIL hit_freeze got l=%0d y=%0d want 2,250", lives, FrogY);
    end
    do_frame(1'b0);
    btn_down = 0;
    checks++;
    if ({FrogX, FrogY} !== {10'd152, 10'd240}) begin
      errors++; $display("FAIL hit_respawn got %0d,%0d want 152,240", FrogX, FrogY);
    end
    do_frame(1'b0);
    checks++;
    if ({lives, FrogY} !== {2'd2, 10'd240}) begin
      errors++; $display("FAIL hit_after got l=%0d y=%0d want 2,240", lives, FrogY);
    end
  endtask

  task automatic test_tick_boundary();
    do_reset();
    do_frame(1'b1);
    checks++;
    if (lives !== 2'd3) begin
      errors++; $display("FAIL tick_ov_same got %0d want 3", lives);
    end
    do_frame(1'b0);
    checks++;
    if (lives !== 2'd2) begin
      errors++; $display("FAIL tick_ov_next got %0d want 2", lives);
    end
  endtask

  task automatic test_croc_bounce();
    do_reset();
    do_frames(100);
    checks++;
    if (CrocY2 !== 9'd400) begin
      errors++; $display("FAIL c2_k100 got %0d want 400", CrocY2);
    end
    do_frame(1'b0);
    checks++;
    if (CrocY2 !== 9'd400) begin
      errors++; $display("FAIL c2_k101 got %0d want 400", CrocY2);
    end
    do_frame(1'b0);
    checks++;
    if (CrocY2 !== 9'd398) begin
      errors++; $display("FAIL c2_k102 got %0d want 398", CrocY2);
    end
    do_frames(20);
    checks++;
    if (CrocY3 !== 9'd34) begin
      errors++; $display("FAIL c3_k122 got %0d want 34", CrocY3);
    end
    do_frame(1'b0);
    checks++;
    if (CrocY3 !== 9'd32) begin
      errors++; $display("FAIL c3_k123 got %0d want 32", CrocY3);
    end
    do_frame(1'b0);
    checks++;
    if ({CrocY3, CrocY1} !== {9'd35, 9'd156}) begin
      errors++; $display("FAIL c3_k124 got c3=%0d c1=%0d want 35,156", CrocY3, CrocY1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    croc_ticks = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_long_vsync();
    test_move_clamp();
    test_cancel();
    test_game_over();
    test_hit();
    test_tick_boundary();
    test_croc_bounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
